boot_rom_copier: RTL and testbench

- Initiator for the boot ROM read port (CSN / A / Q, one-cycle registered-address read).
- Streams LEN consecutive 32-bit words from the ROM, starting at SRC_BASE, into a memory slave over a req/gnt write interface, starting at DST_BASE.
- Used at boot to shadow ROM code into instruction/data RAM before the core is released.
- Sustains one word per cycle while MEM_GNT stays high.

---
 rtl/boot_rom_copier.sv | 188 ++++++++++++++++++
 tb/tb_boot_rom_copier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_copier.sv
// boot_rom_copier: shadows LEN words of boot ROM into a memory slave over a req/gnt write port.
// Latency: READ one cycle after the START edge, word k written in cycle 2+k, DONE in cycle LEN+2 (no stalls).
// Backpressure: MEM_GNT low stalls the WRITE state. REQ, ADDR and WDATA hold, and the ROM stays deselected so ROM_Q stays put.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   START, SRC_BASE,       start request (IDLE only), first ROM word address,
//   DST_BASE, LEN          first destination byte address, word count
//   BUSY, DONE             transfer in flight / one-cycle completion pulse
//   ROM_CSN, ROM_A, ROM_Q  ROM read port (registered address, data valid next cycle)
//   MEM_REQ, MEM_GNT,      write request / accept handshake
//   MEM_WE, MEM_BE,        write strobes (constant while requesting)
//   MEM_ADDR, MEM_WDATA    destination byte address and data
//   CHECKSUM               only with BOOT_COPY_CHECKSUM_EN: mod-2^32 sum of granted write data
//
// Optional feature macro: BOOT_COPY_CHECKSUM_EN (undefined by default; the port and adder are then absent).

module boot_rom_copier #(
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = ROM_ADDR_WIDTH + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [ROM_ADDR_WIDTH-1:0] SRC_BASE,
  input  logic [MEM_ADDR_WIDTH-1:0] DST_BASE,
  input  logic [LEN_WIDTH-1:0]      LEN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ROM_CSN,
  output logic [ROM_ADDR_WIDTH-1:0] ROM_A,
  input  logic [31:0]               ROM_Q,
  output logic                      MEM_REQ,
  input  logic                      MEM_GNT,
  output logic                      MEM_WE,
  output logic [3:0]                MEM_BE,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR,
`ifdef BOOT_COPY_CHECKSUM_EN
  output logic [31:0]               CHECKSUM,
`endif
  output logic [31:0]               MEM_WDATA
);

  // Word counter must hold 2^ROM_ADDR_WIDTH, the largest transfer the ROM can supply.
  localparam int CNT_W = ROM_ADDR_WIDTH + 1;
  localparam int CMP_W = (LEN_WIDTH > CNT_W) ? LEN_WIDTH : CNT_W;
  localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ROM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ROM_ADDR_WIDTH-1:0] src_q;
  logic [MEM_ADDR_WIDTH-1:0] dst_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          idx_q;

  logic                      start_acc;
  logic                      adv;

  // Clamp the requested length to the ROM size; longer requests would only re-read wrapped words.
  logic [CMP_W-1:0]          len_ext;
  logic [CNT_W-1:0]          len_eff;

  assign len_ext = CMP_W'(LEN);
  assign len_eff = (len_ext > MAX_WORDS) ? CNT_W'(MAX_WORDS) : CNT_W'(len_ext);

  // Address arithmetic. ROM addresses wrap by truncation to ROM_ADDR_WIDTH bits,
  // destination addresses wrap at 2^MEM_ADDR_WIDTH.
  logic [CNT_W-1:0]          idx_nxt;
  logic                      last_word;
  logic [ROM_ADDR_WIDTH-1:0] rd_addr;
  logic [ROM_ADDR_WIDTH-1:0] rd_addr_nxt;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr;

  assign idx_nxt     = idx_q + CNT_W'(1);
  assign last_word   = (idx_nxt == cnt_q);
  assign rd_addr     = src_q + idx_q[ROM_ADDR_WIDTH-1:0];
  assign rd_addr_nxt = src_q + idx_nxt[ROM_ADDR_WIDTH-1:0];
  assign wr_addr     = dst_q + MEM_ADDR_WIDTH'({idx_q, 2'b00});

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        src_q <= SRC_BASE;
        dst_q <= DST_BASE;
        cnt_q <= len_eff;
        idx_q <= '0;
      end else if (adv) begin
        idx_q <= idx_nxt;
      end
    end
  end

  // Next state and outputs. The ROM is only selected in READ, and in WRITE on the
  // cycle a non-final word is granted. That prefetch keeps one word per cycle
  // streaming. It also leaves ROM_Q, and so MEM_WDATA, frozen during a stall.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    adv       = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    ROM_CSN   = 1'b1;
    ROM_A     = '0;
    MEM_REQ   = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          state_d   = (len_eff == '0) ? S_FIN : S_READ;
        end
      end

      S_READ: begin
        BUSY    = 1'b1;
        ROM_CSN = 1'b0;
        ROM_A   = rd_addr;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        BUSY      = 1'b1;
        MEM_REQ   = 1'b1;
        MEM_ADDR  = wr_addr;
        MEM_WDATA = ROM_Q;
        if (MEM_GNT) begin
          if (last_word) begin
            state_d = S_FIN;
          end else begin
            ROM_CSN = 1'b0;
            ROM_A   = rd_addr_nxt;
            adv     = 1'b1;
          end
        end
      end

      S_FIN: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign MEM_WE = MEM_REQ;
  assign MEM_BE = 4'hF;

`ifdef BOOT_COPY_CHECKSUM_EN
  // Running sum of accepted writes. It is only cleared by a new START, so it
  // stays valid from DONE onwards.
  logic [31:0] csum_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      csum_q <= '0;
    end else if (start_acc) begin
      csum_q <= '0;
    end else if (MEM_REQ && MEM_GNT) begin
      csum_q <= csum_q + MEM_WDATA;
    end
  end

  assign CHECKSUM = csum_q;
`endif

endmodule

// File: tb/tb_boot_rom_copier.sv
module tb_boot_rom_copier;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [9:0]  SRC_BASE;
  logic [31:0] DST_BASE;
  logic [10:0] LEN;
  logic        BUSY;
  logic        DONE;
  logic        ROM_CSN;
  logic [9:0]  ROM_A;
  logic [31:0] ROM_Q = '0;
  logic        MEM_REQ;
  logic        MEM_GNT;
  logic        MEM_WE;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
`ifdef BOOT_COPY_CHECKSUM_EN
  logic [31:0] CHECKSUM;
`endif

  boot_rom_copier dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SRC_BASE  (SRC_BASE),
    .DST_BASE  (DST_BASE),
    .LEN       (LEN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ROM_CSN   (ROM_CSN),
    .ROM_A     (ROM_A),
    .ROM_Q     (ROM_Q),
    .MEM_REQ   (MEM_REQ),
    .MEM_GNT   (MEM_GNT),
    .MEM_WE    (MEM_WE),
    .MEM_BE    (MEM_BE),
    .MEM_ADDR  (MEM_ADDR),
`ifdef BOOT_COPY_CHECKSUM_EN
    .CHECKSUM  (CHECKSUM),
`endif
    .MEM_WDATA (MEM_WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM model: mem[k] = k*3, registered address, output held while deselected.
  always @(posedge CLK) begin
    if (ROM_CSN === 1'b0) ROM_Q <= 32'(ROM_A) * 32'd3;
  end

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] exp_sum;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Write monitor: scoreboard pop on every granted write, plus hold checks on stalls.
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(negedge CLK) begin
    wr_t e;
    if (prev_req === 1'b1 && prev_gnt === 1'b0 && prev_rst === 1'b0) begin
      chk("stall_req_held", 64'(MEM_REQ), 64'd1);
      chk("stall_addr_held", 64'(MEM_ADDR), 64'(prev_addr));
      chk("stall_data_held", 64'(MEM_WDATA), 64'(prev_data));
    end
    if (MEM_REQ === 1'b1) begin
      chk("mem_we", 64'(MEM_WE), 64'd1);
      chk("mem_be", 64'(MEM_BE), 64'hF);
      if (MEM_GNT === 1'b0) begin
        chk("stall_csn_high", 64'(ROM_CSN), 64'd1);
      end else begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL extra_write: observed addr=%0h with empty scoreboard, expected no write", MEM_ADDR);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", 64'(MEM_ADDR), 64'(e.addr));
          chk("wr_data", 64'(MEM_WDATA), 64'(e.data));
        end
      end
    end
    prev_req  = MEM_REQ;
    prev_gnt  = MEM_GNT;
    prev_rst  = RST;
    prev_addr = MEM_ADDR;
    prev_data = MEM_WDATA;
  end

  // Drives one START pulse accepted at the next edge (edge 0) and pushes the expected writes.
  // Returns #1 after edge 0, i.e. at the start of cycle 1.
  task automatic start_xfer(input logic [9:0] src, input logic [31:0] dst, input logic [10:0] len);
    int eff;
    @(posedge CLK); #1;
    SRC_BASE = src;
    DST_BASE = dst;
    LEN      = len;
    START    = 1'b1;
    eff      = (int'(len) > 1024) ? 1024 : int'(len);
    exp_sum  = '0;
    for (int k = 0; k < eff; k++) begin
      wr_t w;
      w.addr  = dst + 32'(4 * k);
      w.data  = 32'((int'(src) + k) % 1024) * 32'd3;
      exp_sum = exp_sum + w.data;
      sb.push_back(w);
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Waits (bounded) for DONE and checks cycle position and activity counts.
  task automatic run_check(input string tag, input int exp_n, input int exp_csn,
                           input int exp_req, input int limit);
    int n, csn_lo, req_c, busy_c;
    n = 0; csn_lo = 0; req_c = 0; busy_c = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CLK);
      if (ROM_CSN === 1'b0) csn_lo++;
      if (MEM_REQ === 1'b1) req_c++;
      if (BUSY === 1'b1) busy_c++;
      if (DONE === 1'b1) begin
        n = i;
        break;
      end
    end
    chk({tag, "_done_cycle"}, 64'(n), 64'(exp_n));
    chk({tag, "_csn_low_cycles"}, 64'(csn_lo), 64'(exp_csn));
    chk({tag, "_req_cycles"}, 64'(req_c), 64'(exp_req));
    chk({tag, "_busy_cycles"}, 64'(busy_c), 64'(exp_n - 1));
    chk({tag, "_words_left"}, 64'(sb.size()), 64'd0);
`ifdef BOOT_COPY_CHECKSUM_EN
    chk({tag, "_checksum"}, 64'(CHECKSUM), 64'(exp_sum));
`endif
  endtask

  initial begin
    RST      = 1'b1;
    START    = 1'b0;
    SRC_BASE = '0;
    DST_BASE = '0;
    LEN      = '0;
    MEM_GNT  = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_csn", 64'(ROM_CSN), 64'd1);
    chk("rst_rom_a", 64'(ROM_A), 64'd0);
    chk("rst_req", 64'(MEM_REQ), 64'd0);
    chk("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
    RST = 1'b0;

    // Basic copy: data 15,18,21,24 at 0x100..0x10C, DONE in cycle 6
    start_xfer(10'd5, 32'h100, 11'd4);
    run_check("basic", 6, 4, 4, 50);
`ifdef BOOT_COPY_CHECKSUM_EN
    chk("basic_checksum_78", 64'(CHECKSUM), 64'd78);
`endif

    // Same copy, GNT low for 3 cycles on the second write
    start_xfer(10'd5, 32'h100, 11'd4);
    fork
      begin
        repeat (2) @(posedge CLK);
        #1 MEM_GNT = 1'b0;
        @(negedge CLK);
        chk("stall_addr_0x104", 64'(MEM_ADDR), 64'h104);
        chk("stall_data_18", 64'(MEM_WDATA), 64'd18);
        repeat (3) @(posedge CLK);
        #1 MEM_GNT = 1'b1;
      end
    join_none
    run_check("stall", 9, 4, 7, 50);

    // ROM address wrap: 1022, 1023, 0, 1
    start_xfer(10'd1022, 32'h300, 11'd4);
    run_check("wrap", 6, 4, 4, 50);

    // Zero length: DONE next cycle, no ROM access, no write
    start_xfer(10'd5, 32'h400, 11'd0);
    run_check("len0", 1, 0, 0, 50);

    // Reset while a write is pending
    start_xfer(10'd5, 32'h100, 11'd4);
    @(posedge CLK); #1;
    MEM_GNT = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_req", 64'(MEM_REQ), 64'd0);
    chk("midrst_csn", 64'(ROM_CSN), 64'd1);
    chk("midrst_busy", 64'(BUSY), 64'd0);
    sb.delete();
    MEM_GNT = 1'b1;
    start_xfer(10'd0, 32'h200, 11'd3);
    run_check("after_rst", 5, 3, 3, 50);

    // START pulsed while busy is ignored
    start_xfer(10'd5, 32'h100, 11'd4);
    fork
      begin
        repeat (2) @(posedge CLK);
        #1;
        START    = 1'b1;
        SRC_BASE = 10'd100;
        LEN      = 11'd1;
        @(posedge CLK); #1;
        START = 1'b0;
      end
    join_none
    run_check("ignored_start", 6, 4, 4, 50);
    repeat (2) @(posedge CLK);
    #1;
    chk("ignored_start_idle", 64'(BUSY), 64'd0);

    // LEN=2047 clamps to 1024 words (source wraps past 1023)
    start_xfer(10'd10, 32'h1000, 11'd2047);
    run_check("clamp", 1026, 1024, 1024, 1200);

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
